// File: rtl/mem_port_arbiter.sv
// Shares one memory port between icache and dcache, one transaction at a time.
// MEM_ARB_RR_EN selects round-robin ties; otherwise dcache wins every tie.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_req_valid_i,
  input  logic [ADDR_W-1:0] icache_addr_i,
  input  logic              icache_data_wen_i,
  input  logic [DATA_W-1:0] icache_data_i,
  output logic              icache_data_valid_o,
  output logic [DATA_W-1:0] icache_data_o,
  input  logic              dcache_req_valid_i,
  input  logic [ADDR_W-1:0] dcache_addr_i,
  input  logic              dcache_data_wen_i,
  input  logic [DATA_W-1:0] dcache_data_i,
  output logic              dcache_data_valid_o,
  output logic [DATA_W-1:0] dcache_data_o,
  output logic              mem_req_valid_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_data_wen_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_data_valid_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [1:0]        grant_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_cnt;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_data;

  logic w_any;
  logic w_pick_d;
  logic w_busy;
  logic w_resp;
  logic w_tmo;
  logic w_done;
  logic w_own_i;
  logic w_own_d;

  assign w_any   = icache_req_valid_i | dcache_req_valid_i;
  assign w_own_i = (r_state == GNT_I);
  assign w_own_d = (r_state == GNT_D);
  assign w_busy  = w_own_i | w_own_d;
  assign w_resp  = w_busy & mem_data_valid_i;
  assign w_tmo   = w_busy & (r_cnt == TO_LAST);
  assign w_done  = w_resp | w_tmo;

`ifdef MEM_ARB_RR_EN
  // r_last_d = 1 when dcache held the most recent grant
  logic r_last_d;

  always_comb begin
    w_pick_d = dcache_req_valid_i;
    if (icache_req_valid_i && dcache_req_valid_i)
      w_pick_d = ~r_last_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_last_d <= 1'b0;
    else if (r_state == IDLE && w_any)
      r_last_d <= w_pick_d;
  end
`else
  always_comb begin
    w_pick_d = dcache_req_valid_i;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_any)
          w_next = w_pick_d ? GNT_D : GNT_I;
      end
      GNT_I, GNT_D: begin
        if (w_done)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_req  <= 1'b0;
      r_addr <= '0;
      r_wen  <= 1'b0;
      r_data <= '0;
    end else begin
      r_req <= (w_next != IDLE);
      if (!w_busy || w_done)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 16'd1;
      if (r_state == IDLE && w_any) begin
        r_addr <= w_pick_d ? dcache_addr_i : icache_addr_i;
        r_wen  <= w_pick_d ? dcache_data_wen_i
                           : icache_data_wen_i;
        r_data <= w_pick_d ? dcache_data_i : icache_data_i;
      end
    end
  end

  assign mem_req_valid_o = r_req;
  assign mem_addr_o      = r_addr;
  assign mem_data_wen_o  = r_wen;
  assign mem_data_o      = r_data;
  assign grant_o         = {w_own_d, w_own_i};
  assign err_o           = w_tmo & ~mem_data_valid_i;

  // Timeout completions return zero data
  assign icache_data_valid_o = w_own_i & w_done;
  assign icache_data_o = (w_own_i & w_resp) ? mem_data_i : '0;
  assign dcache_data_valid_o = w_own_d & w_done;
  assign dcache_data_o = (w_own_d & w_resp) ? mem_data_i : '0;

endmodule
